// File: rtl/fp_sqrt_arb.sv
// fp_sqrt_arb: round-robin arbiter that shares one multi-cycle fp_sqrt unit
// between NUM_REQ requesters, with one operation in flight at a time.
//
// Ports
//   clk_i, reset_i        clock, asynchronous active-high reset
//   req_valid_i/ready_o   per-requester request handshake (ready one-hot or 0)
//   req_a_i, req_rnd_i    packed operands / rounding modes, slice i = requester i
//   rsp_valid_o/ready_i   one-hot response handshake
//   rsp_result_o          captured fp_sqrt result (zero on a watchdog abort)
//   rsp_rnd_o             rounding mode travelling with the response
//   rsp_timeout_o         response produced by a watchdog abort
//   sqrt_start_o, sqrt_a_o, sqrt_rnd_o, sqrt_done_i, sqrt_result_i
//                         connection to the fp_sqrt unit
//   busy_o, grant_id_o    FSM not idle / current owner of the unit
//
// Build option: define FP_SQRT_ARB_WDT_EN to enable the WAIT-state watchdog
// (limit WDT_CYCLES). Without it rsp_timeout_o is tied low and WAIT lasts
// until sqrt_done_i.

package fp_sqrt_arb_pkg;
  typedef enum logic [1:0] {FP32 = 2'd0, FP64 = 2'd1, FP16 = 2'd2, BF16 = 2'd3} fp_format_e;
  typedef enum logic [2:0] {RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4} roundmode_e;

  localparam int unsigned MAX_FP_WIDTH = 64;

  typedef struct packed {
    logic [MAX_FP_WIDTH-1:0] u_result;
    logic                    round_en;
    logic [4:0]              status;
  } uround_res_t;

  function automatic int unsigned fp_width(fp_format_e f);
    case (f)
      FP64:       return 64;
      FP16, BF16: return 16;
      default:    return 32;
    endcase
  endfunction
endpackage

module fp_sqrt_arb
  import fp_sqrt_arb_pkg::*;
#(
  parameter int         NUM_REQ    = 4,
  parameter fp_format_e FP_FORMAT  = FP32,
  parameter int         WDT_CYCLES = 64,
  localparam int        FP_WIDTH   = fp_width(FP_FORMAT),
  localparam int        ID_W       = $clog2(NUM_REQ)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ*FP_WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*3-1:0]        req_rnd_i,
  output logic [NUM_REQ-1:0]          rsp_valid_o,
  input  logic [NUM_REQ-1:0]          rsp_ready_i,
  output uround_res_t                 rsp_result_o,
  output logic [2:0]                  rsp_rnd_o,
  output logic                        rsp_timeout_o,
  output logic                        sqrt_start_o,
  output logic [FP_WIDTH-1:0]         sqrt_a_o,
  output logic [2:0]                  sqrt_rnd_o,
  input  logic                        sqrt_done_i,
  input  uround_res_t                 sqrt_result_i,
  output logic                        busy_o,
  output logic [ID_W-1:0]             grant_id_o
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || WDT_CYCLES < 1) begin : g_param_check
    $error("fp_sqrt_arb: unsupported parameter value");
  end

  localparam int                CW        = ID_W + 1;
  localparam logic [CW-1:0]     NUM_REQ_C = CW'(NUM_REQ);
  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e               state;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      grant_id;
  logic [FP_WIDTH-1:0]  op_a;
  logic [2:0]           op_rnd;
  uround_res_t          res;
  logic                 start;
  logic [NUM_REQ-1:0]   rsp_vld;

  logic [ID_W-1:0]      winner;
  logic                 any_req;
  logic [CW-1:0]        cand;

  logic [FP_WIDTH-1:0]  a_arr   [NUM_REQ];
  logic [2:0]           rnd_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g]   = req_a_i[g*FP_WIDTH +: FP_WIDTH];
    assign rnd_arr[g] = req_rnd_i[g*3 +: 3];
  end

  // Search from rr_ptr upward with wrap. Walking the offsets from highest to
  // lowest lets the closest valid requester overwrite the farther ones.
  always_comb begin
    winner  = rr_ptr;
    any_req = 1'b0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + CW'(k);
      if (cand >= NUM_REQ_C) cand = cand - NUM_REQ_C;
      if (req_valid_i[cand[ID_W-1:0]]) begin
        winner  = cand[ID_W-1:0];
        any_req = 1'b1;
      end
    end
  end

`ifdef FP_SQRT_ARB_WDT_EN
  localparam int              WDT_W    = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);
  logic [WDT_W-1:0] wdt_cnt;
  logic             timeout;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      op_a     <= '0;
      op_rnd   <= '0;
      res      <= '0;
      start    <= 1'b0;
      rsp_vld  <= '0;
`ifdef FP_SQRT_ARB_WDT_EN
      wdt_cnt  <= '0;
      timeout  <= 1'b0;
`endif
    end else begin
      start <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id <= winner;
            op_a     <= a_arr[winner];
            op_rnd   <= rnd_arr[winner];
            start    <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef FP_SQRT_ARB_WDT_EN
          wdt_cnt <= '0;
`endif
        end
        WAIT: begin
          if (sqrt_done_i) begin
            res     <= sqrt_result_i;
            rsp_vld <= ONE << grant_id;
            state   <= RESP;
          end
`ifdef FP_SQRT_ARB_WDT_EN
          // WAIT cycle number WDT_CYCLES without done: abort with a zero result.
          else if (wdt_cnt == WDT_LAST) begin
            res     <= '0;
            timeout <= 1'b1;
            rsp_vld <= ONE << grant_id;
            state   <= RESP;
          end else begin
            wdt_cnt <= wdt_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          // rsp_vld holds only the granted bit, so other readies are masked.
          if (|(rsp_vld & rsp_ready_i)) begin
            rsp_vld <= '0;
            rr_ptr  <= (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
            state   <= IDLE;
`ifdef FP_SQRT_ARB_WDT_EN
            timeout <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Ready is gated with reset so it stays low while reset is asserted even
  // if requests are already pending.
  assign req_ready_o  = (state == IDLE && any_req && !reset_i) ? (ONE << winner) : '0;
  assign rsp_valid_o  = rsp_vld;
  assign rsp_result_o = res;
  assign rsp_rnd_o    = op_rnd;
  assign sqrt_start_o = start;
  assign sqrt_a_o     = op_a;
  assign sqrt_rnd_o   = op_rnd;
  assign busy_o       = (state != IDLE);
  assign grant_id_o   = grant_id;
`ifdef FP_SQRT_ARB_WDT_EN
  assign rsp_timeout_o = timeout;
`else
  assign rsp_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_fp_sqrt_arb.sv
// tb_fp_sqrt_arb: self-checking bench for fp_sqrt_arb (NUM_REQ=4, FP32).
// A behavioural fp_sqrt stub answers each start after a programmable latency;
// expected responses are queued at grant time and compared at the response
// handshake.
module tb_fp_sqrt_arb;
  import fp_sqrt_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset     = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    rsp_ready = '1;
  logic [N*W-1:0]  req_a     = '0;
  logic [N*3-1:0]  req_rnd   = '0;
  logic [N-1:0]    req_ready, rsp_valid;
  uround_res_t     rsp_result;
  uround_res_t     sqrt_result = '0;
  logic [2:0]      rsp_rnd, sqrt_rnd;
  logic            rsp_timeout, sqrt_start, busy;
  logic            sqrt_done = 1'b0;
  logic [W-1:0]    sqrt_a;
  logic [1:0]      grant_id;

  fp_sqrt_arb dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_rnd_i(req_rnd),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_rnd_o(rsp_rnd), .rsp_timeout_o(rsp_timeout),
    .sqrt_start_o(sqrt_start), .sqrt_a_o(sqrt_a), .sqrt_rnd_o(sqrt_rnd),
    .sqrt_done_i(sqrt_done), .sqrt_result_i(sqrt_result),
    .busy_o(busy), .grant_id_o(grant_id)
  );

  int n_checks    = 0;
  int n_fail      = 0;
  int cyc         = 0;
  int sqrt_lat    = 0;
  int stub_cnt    = -1;
  int done_pulses = 0;
  logic [31:0] stub_a = '0;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [2:0]  rnd;
    logic [31:0] res;
    logic        tmo;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [2:0]  rnd;
    int          lat;
    logic [31:0] res;
  } vec_t;
  vec_t vecs[6];

  task automatic check(string name, logic [127:0] got, logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Known square roots the stub can answer.
  function automatic logic [31:0] ref_sqrt(logic [31:0] a);
    case (a)
      32'h4080_0000: return 32'h4000_0000;  // 4    -> 2
      32'h4110_0000: return 32'h4040_0000;  // 9    -> 3
      32'h4180_0000: return 32'h4080_0000;  // 16   -> 4
      32'h3F80_0000: return 32'h3F80_0000;  // 1    -> 1
      32'h42C8_0000: return 32'h4120_0000;  // 100  -> 10
      32'h3E80_0000: return 32'h3F00_0000;  // 0.25 -> 0.5
      32'h0000_0000: return 32'h0000_0000;
      default:       return 32'h7FC0_0000;
    endcase
  endfunction

  function automatic uround_res_t mk_res(logic [31:0] a);
    uround_res_t r;
    r          = '0;
    r.u_result = {32'h0, ref_sqrt(a)};
    r.round_en = 1'b1;
    return r;
  endfunction

  // fp_sqrt stub: done is high in the cycle sqrt_lat cycles after the first
  // WAIT cycle. It ignores the arbiter reset on purpose.
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    sqrt_done <= 1'b0;
    if (sqrt_start) begin
      stub_a <= sqrt_a;
      if (sqrt_lat == 0) begin
        sqrt_done   <= 1'b1;
        sqrt_result <= mk_res(sqrt_a);
      end else begin
        stub_cnt <= sqrt_lat - 1;
      end
    end else if (stub_cnt == 0) begin
      sqrt_done   <= 1'b1;
      sqrt_result <= mk_res(stub_a);
      stub_cnt    <= -1;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
    end
  end

  // Scoreboard: compare on every response handshake.
  always @(negedge clk) begin
    exp_t e;
    if (sqrt_done) done_pulses++;
    if (rsp_valid != '0 && exp_q.size() == 0) begin
      check("unexpected_rsp", 128'(rsp_valid), 128'(0));
    end else if ((rsp_valid & rsp_ready) != '0) begin
      e = exp_q.pop_front();
      check("rsp_valid", 128'(rsp_valid), 128'(N'(1) << e.id));
      check("rsp_result", 128'(rsp_result.u_result), 128'({32'h0, e.res}));
      check("rsp_round_en", 128'(rsp_result.round_en), 128'(!e.tmo));
      check("rsp_rnd", 128'(rsp_rnd), 128'(e.rnd));
      check("rsp_timeout", 128'(rsp_timeout), 128'(e.tmo));
      check("sqrt_a_stable", 128'(sqrt_a), 128'(e.a));
      check("grant_id_stable", 128'(grant_id), 128'(e.id));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int id, logic [31:0] a, logic [2:0] rnd);
    req_a[id*W +: W]   = a;
    req_rnd[id*3 +: 3] = rnd;
    req_valid[id]      = 1'b1;
  endtask

  task automatic await_accept(input int id, input logic [31:0] a, input logic [2:0] rnd,
                              input logic [31:0] res, input logic tmo, output int t_acc);
    bit   got;
    exp_t e;
    got   = 1'b0;
    t_acc = -1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (req_ready != '0) got = 1'b1;
    end
    if (!got) begin
      check("accept_timeout", 128'(0), 128'(1));
      return;
    end
    check("grant", 128'(req_ready), 128'(N'(1) << id));
    t_acc = cyc;
    e.id = id; e.a = a; e.rnd = rnd; e.res = res; e.tmo = tmo;
    exp_q.push_back(e);
  endtask

  task automatic await_rsp(output int t_rsp);
    bit got;
    got   = 1'b0;
    t_rsp = -1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid != '0) got = 1'b1;
    end
    if (!got) check("rsp_timeout_wait", 128'(0), 128'(1));
    else      t_rsp = cyc;
  endtask

  task automatic run_op(vec_t v);
    int t_acc, t_rsp;
    sqrt_lat = v.lat;
    step();
    set_req(v.id, v.a, v.rnd);
    await_accept(v.id, v.a, v.rnd, v.res, 1'b0, t_acc);
    step();
    req_valid[v.id] = 1'b0;
    await_rsp(t_rsp);
    check("latency", 128'(t_rsp - t_acc), 128'(3 + v.lat));
  endtask

  logic [31:0] rr_op  [N] = '{32'h4080_0000, 32'h4110_0000, 32'h4180_0000, 32'h3E80_0000};
  logic [31:0] rr_res [N] = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h3F00_0000};

  initial begin
    int t_acc, t_rsp, d0, bad;
    logic [76:0] hold;

    vecs[0] = '{2, 32'h4080_0000, 3'd0, 12, 32'h4000_0000};
    vecs[1] = '{0, 32'h4110_0000, 3'd1,  0, 32'h4040_0000};
    vecs[2] = '{3, 32'h3F80_0000, 3'd2,  1, 32'h3F80_0000};
    vecs[3] = '{1, 32'h42C8_0000, 3'd3,  5, 32'h4120_0000};
    vecs[4] = '{3, 32'h3E80_0000, 3'd4,  7, 32'h3F00_0000};
    vecs[5] = '{0, 32'h0000_0000, 3'd0,  2, 32'h0000_0000};

    // Reset with all requests pending: every output must stay low.
    reset     = 1'b1;
    req_a     = {4{32'h4080_0000}};
    req_valid = '1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 128'(req_ready), 128'(0));
    check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_grant_id", 128'(grant_id), 128'(0));
    check("rst_sqrt_start", 128'(sqrt_start), 128'(0));
    check("rst_timeout", 128'(rsp_timeout), 128'(0));
    check("rst_sqrt_a", 128'(sqrt_a), 128'(0));
    check("rst_result", 128'(rsp_result), 128'(0));
    step();
    reset     = 1'b0;
    req_valid = '0;

    // Table of single operations.
    for (int i = 0; i < 6; i++) run_op(vecs[i]);

    // Reset in the middle of WAIT: the operation is dropped and the late
    // done from the stub must not produce a response.
    sqrt_lat = 20;
    step();
    set_req(1, 32'h4110_0000, 3'd0);
    await_accept(1, 32'h4110_0000, 3'd0, 32'h4040_0000, 1'b0, t_acc);
    step();
    req_valid[1] = 1'b0;
    step();
    step();
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_rsp_valid", 128'(rsp_valid), 128'(0));
    check("midrst_grant_id", 128'(grant_id), 128'(0));
    step();
    reset = 1'b0;
    exp_q.delete();
    d0  = done_pulses;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid != '0 || busy) bad++;
    end
    check("midrst_no_rsp", 128'(bad), 128'(0));
    check("midrst_late_done", 128'(done_pulses - d0), 128'(1));

    // Round robin with all four requesters valid; rr_ptr restarts at 0.
    sqrt_lat = 2;
    step();
    for (int i = 0; i < N; i++) set_req(i, rr_op[i], 3'(i));
    for (int k = 0; k < 8; k++) begin
      await_accept(k % N, rr_op[k % N], 3'(k % N), rr_res[k % N], 1'b0, t_acc);
      await_rsp(t_rsp);
    end
    step();
    req_valid = '0;

    // One requester held valid is granted again on each IDLE visit.
    step();
    set_req(3, 32'h3E80_0000, 3'd2);
    for (int k = 0; k < 2; k++) begin
      await_accept(3, 32'h3E80_0000, 3'd2, 32'h3F00_0000, 1'b0, t_acc);
      await_rsp(t_rsp);
    end
    step();
    req_valid = '0;

    // Backpressure on requester 2; other readies high must be ignored and a
    // request from requester 0 raised meanwhile must wait.
    sqrt_lat = 3;
    step();
    rsp_ready = 4'b1011;
    set_req(2, 32'h4180_0000, 3'd1);
    await_accept(2, 32'h4180_0000, 3'd1, 32'h4080_0000, 1'b0, t_acc);
    step();
    req_valid[2] = 1'b0;
    set_req(0, 32'h4080_0000, 3'd4);
    await_rsp(t_rsp);
    hold = {rsp_valid, rsp_result, rsp_rnd};
    repeat (5) begin
      @(negedge clk);
      check("bp_hold", 128'({rsp_valid, rsp_result, rsp_rnd, req_ready, sqrt_start, busy}),
            128'({hold, 4'b0000, 1'b0, 1'b1}));
    end
    step();
    rsp_ready = '1;
    await_accept(0, 32'h4080_0000, 3'd4, 32'h4000_0000, 1'b0, t_acc);
    check("bp_accept_after_rsp", 128'(t_acc - t_rsp >= 7), 128'(1));
    step();
    req_valid[0] = 1'b0;
    await_rsp(t_rsp);

`ifdef FP_SQRT_ARB_WDT_EN
    // Watchdog: done withheld past the limit, arrives later and is ignored.
    sqrt_lat = 100;
    step();
    set_req(1, 32'h4110_0000, 3'd3);
    await_accept(1, 32'h4110_0000, 3'd3, 32'h0000_0000, 1'b1, t_acc);
    step();
    req_valid[1] = 1'b0;
    await_rsp(t_rsp);
    check("wdt_latency", 128'(t_rsp - t_acc), 128'(2 + 64));
    d0 = done_pulses;
    repeat (60) @(negedge clk);
    check("wdt_late_done_seen", 128'(done_pulses - d0), 128'(1));
    check("wdt_idle_after", 128'({busy, rsp_valid}), 128'(0));
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
